mem_write_monitor: RTL and testbench
====================================

# mem_write_monitor

Synthesizable, parametrised store checker that watches the processor data-memory write port (`memwrite`, `dataadr`, `writedata`) and compares each committed store, in order, against a programmed queue of expected (address, data) pairs. It replaces the single hard-coded "store 7 to address 84, tolerate address 80" pass/fail check with a loadable multi-store sequence, a timeout, and captured error information. It sits beside `top` in simulation and on FPGA builds, driving pass/fail status LEDs or a bench `$stop`.

## Interface
- `ADDR_W`, 32, width of `dataadr`
- `DATA_W`, 32, width of `writedata`
- `DEPTH`, 8, expected-store queue depth (power of two, ≥2)
- `TIMEOUT`, 1000, max cycles in RUN without a matched store; 0 disables the timeout
- `IGNORE_ADDR`, 80, address whose stores are skipped (only with `MWMON_IGNORE_EN`)
- `CNT_W`, 16, width of `match_cnt`
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `clear`  in  1  synchronous flush: empty the queue, go to IDLE, zero status
- `start`  in  1  IDLE→RUN pulse; ignored in other states
- `exp_valid`  in  1  expected-entry push request
- `exp_ready`  out  1  queue not full; push accepted when `exp_valid & exp_ready`
- `exp_addr`  in  ADDR_W  expected store address
- `exp_data`  in  DATA_W  expected store data
- `exp_last`  in  1  marks the final expected store of the sequence
- `memwrite`  in  1  store commit strobe from the processor
- `dataadr`  in  ADDR_W  store address
- `writedata`  in  DATA_W  store data
- `done`  out  1  state is PASS or FAIL
- `pass`  out  1  state is PASS
- `fail_code`  out  2  0 none, 1 MISMATCH, 2 UNEXPECTED, 3 TIMEOUT
- `match_cnt`  out  CNT_W  number of matched stores since start; saturates
- `err_addr`  out  ADDR_W  address of the offending store
- `err_data`  out  DATA_W  data of the offending store

## Operation
- Reset: state IDLE, queue empty, `exp_ready`=1, all other outputs 0.
- States: IDLE, RUN, PASS, FAIL. IDLE→RUN on `start`. RUN→PASS/FAIL per the rules below. PASS/FAIL are held until `clear` or `reset`. `clear` has priority over every other input and acts from any state.
- Queue: synchronous FIFO of {addr, data, last}. A push is accepted in any state except PASS/FAIL, and only when not full. `exp_ready` = !full from registered pointers, so a push into a full queue stalls even if a pop occurs in the same cycle.
- In RUN, a store is a cycle with `memwrite`=1. The store is compared against the queue head as it stands before the edge. A push in the same cycle into an empty queue does not count.
  - Queue empty → FAIL, code 2.
  - Address or data differs → FAIL, code 1.
  - Both equal → pop the head, increment `match_cnt`. If the head's `last`=1 → PASS.
- On any FAIL caused by a store, `err_addr`/`err_data` capture that store. On TIMEOUT they remain 0.
- Timeout counter: cleared on entering RUN and on every matched store, and increments every other RUN cycle. When it reaches `TIMEOUT` → FAIL, code 3. If a store arrives on that same cycle, the store outcome wins.
- Stores in IDLE, PASS or FAIL are ignored.
- Arithmetic: the timeout counter is sized $clog2(TIMEOUT+1). `match_cnt` saturates at 2^CNT_W−1.

## Timing
- All outputs are registered. The result for a store sampled at edge N is visible after edge N (one-cycle latency).
- Full is asserted the cycle after the DEPTH-th accepted push. Pointers wrap modulo DEPTH, with an extra bit used for full/empty detection.
- Reset asserted mid-RUN clears everything immediately (asynchronous). Deassertion is synchronised by the surrounding design.

## Configuration
- `MWMON_IGNORE_EN` defined: in RUN, stores with `dataadr == IGNORE_ADDR` are skipped. They are not compared, not counted, and do not reset the timeout.
- `MWMON_IGNORE_EN` undefined: every store is compared, and `IGNORE_ADDR` is unused.

## Test plan
- Ignore enabled: push (84,7,last), start, then stores (80,0x20) and (84,7) → after the second store, `pass`=1, `done`=1, `match_cnt`=1, `fail_code`=0.
- Push (84,7,last), start, store (84,6) → `fail_code`=1, `err_addr`=84, `err_data`=6, `pass`=0.
- TIMEOUT=20: push one entry, start, no stores → `fail_code`=3 exactly 20 cycles after start, `err_addr`=0.
- DEPTH=8: push 9 entries back-to-back → `exp_ready`=0 after the 8th push, 9th held; after one matched store the 9th is accepted.
- Reset asserted mid-RUN after 2 matches → outputs 0 and `exp_ready`=1 during reset; a fresh run behaves normally.
- Ignore disabled: push (84,7,last), start, store (80,0) → `fail_code`=1, `err_addr`=80.

Source files
------------

// File: rtl/mem_write_monitor.sv
// mem_write_monitor: in-order checker for processor data-memory stores.
// Expected (addr, data, last) entries are pushed into a small FIFO. In RUN,
// each committed store is compared against the FIFO head. The run ends in
// PASS or FAIL (mismatch, unexpected store or timeout), and the offending
// store is captured.
// Optional feature: define MWMON_IGNORE_EN to skip stores to IGNORE_ADDR
// while in RUN.
module mem_write_monitor #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT     = 1000,
  parameter int IGNORE_ADDR = 80,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              exp_last,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t            state, state_nx;
  logic [1:0]        code_nx;
  logic              err_cap;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_last;
  logic [PW:0]       wr_ptr, rd_ptr;
  logic [PW-1:0]     head;
  logic              full, empty, push, pop;
  logic              skip, store, hit, timeout_hit;
  logic [TW-1:0]     tcnt;

`ifdef MWMON_IGNORE_EN
  assign skip = (dataadr == ADDR_W'(IGNORE_ADDR));
`else
  // Feature compiled out: the compare is kept only so the parameter is referenced.
  assign skip = 1'b0 & (dataadr == ADDR_W'(IGNORE_ADDR));
`endif

  // Extra pointer bit separates full from empty when the indices coincide.
  assign head      = rd_ptr[PW-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign exp_ready = !full;

  assign store = (state == RUN) && memwrite && !skip;
  assign hit   = !empty && (q_addr[head] == dataadr) && (q_data[head] == writedata);
  assign pop   = !clear && store && hit;
  assign push  = !clear && exp_valid && !full && (state == IDLE || state == RUN);

  // Expiry fires on the edge at which the counter would reach TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));

  assign done = (state == PASS) || (state == FAIL);
  assign pass = (state == PASS);

  // State register.
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  // Next state, fail code and error-capture decision. A store outcome takes
  // precedence over a timeout expiring in the same cycle.
  always_comb begin
    state_nx = state;
    code_nx  = fail_code;
    err_cap  = 1'b0;
    if (clear) begin
      state_nx = IDLE;
      code_nx  = 2'd0;
    end else begin
      case (state)
        IDLE: if (start) state_nx = RUN;
        RUN: begin
          if (store) begin
            if (empty) begin
              state_nx = FAIL; code_nx = 2'd2; err_cap = 1'b1;
            end else if (!hit) begin
              state_nx = FAIL; code_nx = 2'd1; err_cap = 1'b1;
            end else if (q_last[head]) begin
              state_nx = PASS;
            end
          end else if (timeout_hit) begin
            state_nx = FAIL; code_nx = 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO storage; the pointers alone track occupancy, so no reset is needed.
  always_ff @(posedge clk)
    if (push) begin
      q_addr[wr_ptr[PW-1:0]] <= exp_addr;
      q_data[wr_ptr[PW-1:0]] <= exp_data;
      q_last[wr_ptr[PW-1:0]] <= exp_last;
    end

  // FIFO pointers; clear flushes the queue.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end

  // Idle-cycle counter: runs only in RUN and restarts on every matched store.
  always_ff @(posedge clk or posedge reset)
    if (reset)                                                 tcnt <= '0;
    else if (clear || state != RUN || pop || TIMEOUT == 0)     tcnt <= '0;
    else                                                       tcnt <= tcnt + 1'b1;

  // Status: fail code, saturating match count, and the captured store.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fail_code <= '0;
      match_cnt <= '0;
      err_addr  <= '0;
      err_data  <= '0;
    end else begin
      fail_code <= code_nx;
      if (clear || (state == IDLE && start)) match_cnt <= '0;
      else if (pop && match_cnt != '1)       match_cnt <= match_cnt + 1'b1;
      if (clear) begin
        err_addr <= '0;
        err_data <= '0;
      end else if (err_cap) begin
        err_addr <= dataadr;
        err_data <= writedata;
      end
    end
endmodule

// File: tb/tb_mem_write_monitor.sv
// Bench for mem_write_monitor: directed scenarios plus randomized runs
// checked against a queue-based reference model.
module tb_mem_write_monitor;
  localparam int AW = 32, DW = 32, DEPTH = 8, TO = 20, CW = 16;

  logic clk = 1'b0;
  logic reset, clear, start, exp_valid, exp_last, memwrite;
  logic [AW-1:0] exp_addr, dataadr;
  logic [DW-1:0] exp_data, writedata;
  logic exp_ready, done, pass;
  logic [1:0] fail_code;
  logic [CW-1:0] match_cnt;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data;

  mem_write_monitor #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO),
                      .IGNORE_ADDR(80), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_last(exp_last), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .done(done), .pass(pass),
    .fail_code(fail_code), .match_cnt(match_cnt), .err_addr(err_addr),
    .err_data(err_data));

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; bit l; } ent_t;
  ent_t mq[$];
  int m_st;  // 0 idle, 1 running, 2 passed, 3 failed
  int m_code, m_cnt, m_t;
  logic [AW-1:0] m_ea;
  logic [DW-1:0] m_ed;
  int vec = 0, miss = 0;

  function automatic void model_reset();
    mq.delete();
    m_st = 0; m_code = 0; m_cnt = 0; m_t = 0; m_ea = '0; m_ed = '0;
  endfunction

  // One clock edge of the reference behaviour, from the inputs now applied.
  function automatic void model_edge();
    bit full, skip, dpush;
    if (reset || clear) begin model_reset(); return; end
    full  = (mq.size() == DEPTH);
    dpush = exp_valid && !full && (m_st < 2);
    skip  = 1'b0;
`ifdef MWMON_IGNORE_EN
    skip = (dataadr == 80);
`endif
    if (m_st == 0) begin
      if (start) begin m_st = 1; m_t = 0; m_cnt = 0; end
    end else if (m_st == 1) begin
      if (memwrite && !skip) begin
        if (mq.size() == 0) begin
          m_st = 3; m_code = 2; m_ea = dataadr; m_ed = writedata;
        end else if (mq[0].a !== dataadr || mq[0].d !== writedata) begin
          m_st = 3; m_code = 1; m_ea = dataadr; m_ed = writedata;
        end else begin
          if (mq[0].l) m_st = 2;
          void'(mq.pop_front());
          if (m_cnt < 65535) m_cnt++;
          m_t = 0;
        end
      end else begin
        m_t++;
        if (m_t == TO) begin m_st = 3; m_code = 3; end
      end
    end
    if (dpush) mq.push_back('{exp_addr, exp_data, exp_last});
  endfunction

  task automatic idle_in();
    clear = 0; start = 0; exp_valid = 0; exp_last = 0; memwrite = 0;
    exp_addr = '0; exp_data = '0; dataadr = '0; writedata = '0;
  endtask

  // Apply one clock with the currently driven inputs; sample 1 ns later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    idle_in(); clear = 1; tick(); clear = 0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit l);
    exp_valid = 1; exp_addr = a; exp_data = d; exp_last = l; tick();
    exp_valid = 0; exp_last = 0;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    memwrite = 1; dataadr = a; writedata = d; tick();
    memwrite = 0; dataadr = '0; writedata = '0;
  endtask

  task automatic test_reset();
    idle_in(); reset = 1;
    @(posedge clk); #1; @(posedge clk); #1;
    model_reset();
    vec++; if ({done, pass, fail_code} !== 4'b0) begin miss++;
      $display("FAIL reset_status got %b want 0000", {done, pass, fail_code}); end
    vec++; if (exp_ready !== 1'b1) begin miss++;
      $display("FAIL reset_ready got %b want 1", exp_ready); end
    vec++; if ({match_cnt, err_addr, err_data} !== '0) begin miss++;
      $display("FAIL reset_regs cnt=%0d ea=%0h ed=%0h want 0", match_cnt, err_addr, err_data); end
    reset = 0;
  endtask

  task automatic test_mismatch();
    do_clear(); push(84, 7, 1); do_start(); do_store(84, 6);
    vec++; if ({done, pass, fail_code} !== 4'b1001) begin miss++;
      $display("FAIL mismatch_status got %b want 1001", {done, pass, fail_code}); end
    vec++; if (err_addr !== 84 || err_data !== 6) begin miss++;
      $display("FAIL mismatch_err got %0d/%0d want 84/6", err_addr, err_data); end
  endtask

  task automatic test_unexpected();
    do_clear(); do_start(); do_store(12, 34);
    vec++; if (fail_code !== 2'd2 || err_addr !== 12 || err_data !== 34) begin miss++;
      $display("FAIL unexpected got code=%0d ea=%0d ed=%0d want 2/12/34", fail_code, err_addr, err_data); end
  endtask

  task automatic test_timeout();
    do_clear(); push(100, 1, 1); do_start();
    for (int i = 1; i <= TO; i++) begin
      tick();
      if (i == TO - 1) begin
        vec++; if (done !== 1'b0) begin miss++;
          $display("FAIL timeout_early got done=%b code=%0d at cycle %0d", done, fail_code, i); end
      end
    end
    vec++; if (fail_code !== 2'd3 || done !== 1'b1) begin miss++;
      $display("FAIL timeout_code got %0d want 3", fail_code); end
    vec++; if (err_addr !== 0 || err_data !== 0) begin miss++;
      $display("FAIL timeout_err got %0h/%0h want 0/0", err_addr, err_data); end
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < 9; i++) begin
      exp_valid = 1; exp_addr = 32'h100 + i; exp_data = i; exp_last = (i == 8);
      tick();
      if (i == 6) begin
        vec++; if (exp_ready !== 1'b1) begin miss++;
          $display("FAIL full_early got ready=%b want 1", exp_ready); end
      end
      if (i == 7) begin
        vec++; if (exp_ready !== 1'b0) begin miss++;
          $display("FAIL full_after8 got ready=%b want 0", exp_ready); end
      end
    end
    start = 1; tick(); start = 0;          // 9th entry still held on the inputs
    memwrite = 1; dataadr = 32'h100; writedata = 0; tick(); memwrite = 0;
    vec++; if (exp_ready !== 1'b1) begin miss++;
      $display("FAIL full_freed got ready=%b want 1", exp_ready); end
    tick();                                  // 9th push accepted here
    exp_valid = 0; exp_last = 0;
    vec++; if (exp_ready !== 1'b0 || match_cnt !== 1) begin miss++;
      $display("FAIL full_ninth got ready=%b cnt=%0d want 0/1", exp_ready, match_cnt); end
    for (int i = 1; i < 9; i++) do_store(32'h100 + i, i);
    vec++; if (pass !== 1'b1 || match_cnt !== 9) begin miss++;
      $display("FAIL full_drain got pass=%b cnt=%0d want 1/9", pass, match_cnt); end
  endtask

  task automatic test_reset_mid();
    do_clear(); push(4, 40, 0); push(8, 80, 0); push(12, 120, 1);
    do_start(); do_store(4, 40); do_store(8, 80);
    vec++; if (match_cnt !== 2) begin miss++;
      $display("FAIL midrst_cnt got %0d want 2", match_cnt); end
    reset = 1; #1;
    model_reset();
    vec++; if ({done, pass, fail_code, match_cnt} !== '0 || exp_ready !== 1'b1) begin miss++;
      $display("FAIL midrst_clear got d=%b p=%b c=%0d n=%0d r=%b", done, pass, fail_code, match_cnt, exp_ready); end
    tick(); reset = 0;
    push(84, 7, 1); do_start(); do_store(84, 7);
    vec++; if (pass !== 1'b1 || match_cnt !== 1) begin miss++;
      $display("FAIL midrst_fresh got pass=%b cnt=%0d want 1/1", pass, match_cnt); end
  endtask

  task automatic test_ignore();
    do_clear(); push(84, 7, 1); do_start();
`ifdef MWMON_IGNORE_EN
    do_store(80, 32'h20); do_store(84, 7);
    vec++; if ({done, pass, fail_code} !== 4'b1100 || match_cnt !== 1) begin miss++;
      $display("FAIL ignore_on got %b cnt=%0d want 1100/1", {done, pass, fail_code}, match_cnt); end
`else
    do_store(80, 0);
    vec++; if (fail_code !== 2'd1 || err_addr !== 80) begin miss++;
      $display("FAIL ignore_off got code=%0d ea=%0d want 1/80", fail_code, err_addr); end
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int n, pst;
      do_clear();
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        exp_valid = 1; exp_addr = 4 * $urandom_range(0, 7);
        exp_data = $urandom_range(0, 3); exp_last = ($urandom_range(0, 5) == 0);
        tick();
      end
      exp_valid = 0; exp_last = 0;
      do_start();
      pst = (it % 5 == 0) ? 3 : 60;
      for (int c = 0; c < 45; c++) begin
        memwrite = ($urandom_range(0, 99) < pst);
        if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
          dataadr = mq[0].a; writedata = mq[0].d;
        end else begin
          dataadr = 4 * $urandom_range(0, 31); writedata = $urandom_range(0, 3);
        end
        exp_valid = ($urandom_range(0, 3) == 0);
        exp_addr = 4 * $urandom_range(0, 7); exp_data = $urandom_range(0, 3);
        exp_last = ($urandom_range(0, 3) == 0);
        tick();
        vec++;
        if ({done, pass, fail_code, match_cnt, err_addr, err_data, exp_ready} !==
            {m_st >= 2, m_st == 2, 2'(m_code), CW'(m_cnt), m_ea, m_ed, mq.size() < DEPTH}) begin
          miss++;
          $display("FAIL random it=%0d c=%0d got d=%b p=%b code=%0d n=%0d ea=%0h ed=%0h r=%b want d=%0d p=%0d code=%0d n=%0d ea=%0h ed=%0h r=%0d",
                   it, c, done, pass, fail_code, match_cnt, err_addr, err_data, exp_ready,
                   m_st >= 2, m_st == 2, m_code, m_cnt, m_ea, m_ed, mq.size() < DEPTH);
        end
      end
      idle_in();
    end
  endtask

  initial begin
    idle_in(); reset = 1;
    test_reset();
    test_mismatch();
    test_unexpected();
    test_timeout();
    test_full();
    test_reset_mid();
    test_ignore();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
